mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer for the single shared 32-bit memory port.
- Requester A is instruction fetch; requester B is the data load/store path.
- Owns the select of the 2:1 word mux that steers address and write data onto the port.
- Runs one transaction at a time and returns completion and read data to the granted requester.

Parameters:
DATA_WIDTH, 32, width of write and read data
ADDR_WIDTH, 32, width of addresses
TIMEOUT, 16, cycles a transaction may wait for MemReady (used only with the optional feature)

Ports:
Clk  input  1  clock, rising edge
Reset_n  input  1  asynchronous, active-low reset
ReqA  input  1  A requests a transaction; held until DoneA
AddrA  input  ADDR_WIDTH  A address
WDataA  input  DATA_WIDTH  A write data
WrA  input  1  A write (1) / read (0)
ReqB, AddrB, WDataB, WrB  input  1/ADDR_WIDTH/DATA_WIDTH/1  same meanings for B
MemReady  input  1  memory completes the presented transaction this cycle
MemRData  input  DATA_WIDTH  memory read data, valid with MemReady
MemValid  output  1  transaction presented to memory
MemAddr  output  ADDR_WIDTH  muxed address
MemWData  output  DATA_WIDTH  muxed write data
MemWr  output  1  muxed write enable, qualified by MemValid
Sel  output  1  mux select: 0 = A, 1 = B
GntA, GntB  output  1  A / B currently owns the port
DoneA, DoneB  output  1  one-cycle completion pulse
RData  output  DATA_WIDTH  read data captured at completion
Err  output  1  completion was a timeout (optional feature only)

Behaviour:
- Reset: all outputs are registered.
  - Asserting Reset_n low asynchronously forces state IDLE.
  - MemValid, GntA, GntB, DoneA, DoneB, MemWr, Err = 0; Sel = 0; MemAddr, MemWData, RData = 0.
  - LastGnt = B, so A wins the first tie.
- States:
  - IDLE: evaluates requests each edge.
    - Eligible = Req high AND that requester's Done not asserted this cycle. This blocks re-grant on a held Req.
    - Only one eligible -> grant it.
    - Both eligible -> grant the one that is not LastGnt (round robin).
    - On grant: latch Addr, WData and Wr of the winner; set Sel, Gnt and MemValid = 1; update LastGnt; go to BUSY_A or BUSY_B.
    - None eligible -> stay in IDLE; Sel holds its last value.
  - BUSY_A / BUSY_B: MemValid, MemAddr, MemWData and MemWr are held stable; other requests are ignored.
    - On an edge with MemReady = 1: RData <= MemRData (reads only; writes leave RData unchanged).
    - Same edge: pulse the owner's Done for exactly one cycle, drop Gnt and MemValid, go to IDLE.
- Latency: Req sampled at edge N -> MemValid from N. With MemReady already high, Done asserts from N+1.
  - Minimum issue interval is 2 cycles per transaction, because IDLE is always visited once.
- Reset mid-transaction: the transaction is abandoned; no Done, no RData update.
- Requester protocol:
  - Req and its operands stay stable until Done.
  - Req may deassert in the Done cycle or stay high for a new back-to-back request, which is evaluated on the following IDLE edge.
- MemReady while in IDLE is ignored.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to BUSY and increments each BUSY cycle without MemReady.
  - When the counter reaches TIMEOUT, the next edge exits to IDLE with the owner's Done = 1 and Err = 1 for one cycle; RData is unchanged.
  - MemReady on that same edge takes priority: normal completion, Err = 0.
- Undefined: no counter; BUSY waits indefinitely for MemReady; Err is tied 0.

Test Plan:
- Reset, then ReqA=1, AddrA=0x100, WrA=0, MemReady tied 1, MemRData=0xDEADBEEF -> Sel=0, MemAddr=0x100 one cycle; DoneA pulse next cycle with RData=0xDEADBEEF.
- ReqA and ReqB both held high for 4 transactions, MemReady=1 -> grants alternate A,B,A,B; each Done is exactly one cycle; never both Gnt high.
- ReqB write, AddrB=0x2000, WDataB=0x12345678, MemReady low 5 cycles then high -> MemValid/MemAddr/MemWData/MemWr=1 stable all 6 cycles; single DoneB; RData unchanged.
- Reset_n pulled low during BUSY_B -> immediately MemValid=0, GntB=0, no DoneB; after release, pending ReqA wins the first grant.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT=4, ReqA, MemReady held 0 -> DoneA=1 and Err=1 after the 4-cycle wait, then IDLE. Repeat with MemReady rising on the terminal edge -> Err=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Arbitrates the single shared memory port between two requesters and runs
//   one transaction at a time.
//     - Requester A is instruction fetch.
//     - Requester B is the data load/store path.
//   The block drives the select of the 2:1 word mux that steers address and
//   write data onto the port. It returns a one-cycle Done pulse, plus the
//   captured read data, to the requester that owned the port.
//
//   Arbitration:
//     - A requester is eligible when its Req is high and its own Done is not
//       asserted in the current cycle. This stops a held Req from being
//       re-granted in the same cycle its previous transaction completes.
//     - When both are eligible, the one that was not granted last wins.
//     - After reset, A wins the first tie.
//
// Optional feature (macro MEM_ARB_TIMEOUT_EN):
//   - A BUSY-cycle counter aborts a transaction that has waited TIMEOUT
//     cycles without MemReady.
//   - The abort completes with Done and Err asserted, and RData unchanged.
//   - MemReady on the terminal edge wins and gives a normal completion.
//   - Without the macro, BUSY waits indefinitely and Err stays 0.
//
// Ports:
//   Clk, Reset_n              clock (rising edge), async active-low reset
//   ReqA/AddrA/WDataA/WrA     requester A transaction request and operands
//   ReqB/AddrB/WDataB/WrB     requester B transaction request and operands
//   MemReady, MemRData        memory completion strobe and read data
//   MemValid/MemAddr/MemWData/MemWr   transaction presented to memory
//   Sel                       mux select, 0 = A, 1 = B
//   GntA, GntB                current port owner
//   DoneA, DoneB              one-cycle completion pulses
//   RData                     read data captured at completion
//   Err                       completion was a timeout (optional feature)
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  ReqA,
    input  logic [ADDR_WIDTH-1:0] AddrA,
    input  logic [DATA_WIDTH-1:0] WDataA,
    input  logic                  WrA,
    input  logic                  ReqB,
    input  logic [ADDR_WIDTH-1:0] AddrB,
    input  logic [DATA_WIDTH-1:0] WDataB,
    input  logic                  WrB,
    input  logic                  MemReady,
    input  logic [DATA_WIDTH-1:0] MemRData,
    output logic                  MemValid,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [DATA_WIDTH-1:0] MemWData,
    output logic                  MemWr,
    output logic                  Sel,
    output logic                  GntA,
    output logic                  GntB,
    output logic                  DoneA,
    output logic                  DoneB,
    output logic [DATA_WIDTH-1:0] RData,
    output logic                  Err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_A = 2'd1,
        BUSY_B = 2'd2
    } state_t;

    state_t                state_r,     state_s;
    logic                  last_gnt_r,  last_gnt_s;   // 1 = B was granted last
    logic                  mem_valid_r, mem_valid_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r,  mem_addr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_r, mem_wdata_s;
    logic                  mem_wr_r,    mem_wr_s;
    logic                  sel_r,       sel_s;
    logic                  gnt_a_r,     gnt_a_s;
    logic                  gnt_b_r,     gnt_b_s;
    logic                  done_a_r,    done_a_s;
    logic                  done_b_r,    done_b_s;
    logic [DATA_WIDTH-1:0] rdata_r,     rdata_s;
    logic                  err_r,       err_s;
    logic                  elig_a_s,    elig_b_s;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt_r, tmo_cnt_s;
    logic          tmo_hit_s;

    // Counter has seen TIMEOUT ready-less BUSY cycles; next edge aborts.
    assign tmo_hit_s = (tmo_cnt_r == CW'(TIMEOUT));
`endif

    // A held Req is not eligible while its previous Done is still showing.
    assign elig_a_s = ReqA & ~done_a_r;
    assign elig_b_s = ReqB & ~done_b_r;

    // Next-state and next-output logic for the arbitration sequencer.
    always_comb begin
        state_s     = state_r;
        last_gnt_s  = last_gnt_r;
        mem_valid_s = mem_valid_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        mem_wr_s    = mem_wr_r;
        sel_s       = sel_r;
        gnt_a_s     = gnt_a_r;
        gnt_b_s     = gnt_b_r;
        done_a_s    = 1'b0;
        done_b_s    = 1'b0;
        rdata_s     = rdata_r;
        err_s       = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        tmo_cnt_s   = tmo_cnt_r;
`endif

        case (state_r)
            IDLE: begin
                // A wins when it is the only one eligible, or on a tie when B went last.
                if (elig_a_s && (!elig_b_s || last_gnt_r)) begin
                    state_s     = BUSY_A;
                    last_gnt_s  = 1'b0;
                    mem_valid_s = 1'b1;
                    mem_addr_s  = AddrA;
                    mem_wdata_s = WDataA;
                    mem_wr_s    = WrA;
                    sel_s       = 1'b0;
                    gnt_a_s     = 1'b1;
                    gnt_b_s     = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                    tmo_cnt_s   = {CW{1'b0}};
`endif
                end else if (elig_b_s) begin
                    state_s     = BUSY_B;
                    last_gnt_s  = 1'b1;
                    mem_valid_s = 1'b1;
                    mem_addr_s  = AddrB;
                    mem_wdata_s = WDataB;
                    mem_wr_s    = WrB;
                    sel_s       = 1'b1;
                    gnt_a_s     = 1'b0;
                    gnt_b_s     = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                    tmo_cnt_s   = {CW{1'b0}};
`endif
                end else begin
                    // Nothing eligible: hold everything, including Sel.
                    state_s = IDLE;
                end
            end

            BUSY_A, BUSY_B: begin
                if (MemReady) begin
                    if (!mem_wr_r) begin
                        rdata_s = MemRData;
                    end else begin
                        rdata_s = rdata_r;
                    end
                    done_a_s    = (state_r == BUSY_A);
                    done_b_s    = (state_r == BUSY_B);
                    gnt_a_s     = 1'b0;
                    gnt_b_s     = 1'b0;
                    mem_valid_s = 1'b0;
                    mem_wr_s    = 1'b0;
                    state_s     = IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
                end else if (tmo_hit_s) begin
                    // Abandon the access; RData keeps its previous value.
                    done_a_s    = (state_r == BUSY_A);
                    done_b_s    = (state_r == BUSY_B);
                    err_s       = 1'b1;
                    gnt_a_s     = 1'b0;
                    gnt_b_s     = 1'b0;
                    mem_valid_s = 1'b0;
                    mem_wr_s    = 1'b0;
                    state_s     = IDLE;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
`else
                end else begin
                    // Keep presenting the transaction until memory accepts it.
                    state_s = state_r;
                end
`endif
            end

            default: begin
                // Unreachable encoding: recover to a quiet IDLE.
                state_s     = IDLE;
                mem_valid_s = 1'b0;
                mem_wr_s    = 1'b0;
                gnt_a_s     = 1'b0;
                gnt_b_s     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r     <= IDLE;
            last_gnt_r  <= 1'b1;
            mem_valid_r <= 1'b0;
            mem_addr_r  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r <= {DATA_WIDTH{1'b0}};
            mem_wr_r    <= 1'b0;
            sel_r       <= 1'b0;
            gnt_a_r     <= 1'b0;
            gnt_b_r     <= 1'b0;
            done_a_r    <= 1'b0;
            done_b_r    <= 1'b0;
            rdata_r     <= {DATA_WIDTH{1'b0}};
            err_r       <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt_r   <= {CW{1'b0}};
`endif
        end else begin
            state_r     <= state_s;
            last_gnt_r  <= last_gnt_s;
            mem_valid_r <= mem_valid_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            mem_wr_r    <= mem_wr_s;
            sel_r       <= sel_s;
            gnt_a_r     <= gnt_a_s;
            gnt_b_r     <= gnt_b_s;
            done_a_r    <= done_a_s;
            done_b_r    <= done_b_s;
            rdata_r     <= rdata_s;
            err_r       <= err_s;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt_r   <= tmo_cnt_s;
`endif
        end
    end

    assign MemValid = mem_valid_r;
    assign MemAddr  = mem_addr_r;
    assign MemWData = mem_wdata_r;
    assign MemWr    = mem_wr_r;
    assign Sel      = sel_r;
    assign GntA     = gnt_a_r;
    assign GntB     = gnt_b_r;
    assign DoneA    = done_a_r;
    assign DoneB    = done_b_r;
    assign RData    = rdata_r;
    assign Err      = err_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter.
//   - Directed scenarios are followed by a randomized phase.
//   - Every cycle, DUT outputs are compared with a transaction-level reference
//     model. The model tracks the current owner, the operands it latched,
//     the tie-break preference and the wait count.
//   - With MEM_ARB_TIMEOUT_EN defined, the bench uses TIMEOUT = 4 and also
//     exercises the abort path.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMO   = 4;
    localparam int WAITS = 3;
`else
    localparam int TMO   = 16;
    localparam int WAITS = 5;
`endif

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          ReqA = 1'b0, WrA = 1'b0, ReqB = 1'b0, WrB = 1'b0;
    logic [AW-1:0] AddrA = '0, AddrB = '0;
    logic [DW-1:0] WDataA = '0, WDataB = '0;
    logic          MemReady = 1'b0;
    logic [DW-1:0] MemRData = '0;
    logic          MemValid, MemWr, Sel, GntA, GntB, DoneA, DoneB, Err;
    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemWData, RData;

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .ReqA(ReqA), .AddrA(AddrA), .WDataA(WDataA), .WrA(WrA),
        .ReqB(ReqB), .AddrB(AddrB), .WDataB(WDataB), .WrB(WrB),
        .MemReady(MemReady), .MemRData(MemRData),
        .MemValid(MemValid), .MemAddr(MemAddr), .MemWData(MemWData), .MemWr(MemWr),
        .Sel(Sel), .GntA(GntA), .GntB(GntB), .DoneA(DoneA), .DoneB(DoneB),
        .RData(RData), .Err(Err)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            owner;          // 0 = port free, 1 = A, 2 = B
    bit            b_served_last;  // tie goes to A when B was served last
    int            waited;         // ready-less cycles of the current transaction
    logic          e_valid, e_wr, e_sel, e_gnt_a, e_gnt_b, e_done_a, e_done_b, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;

    task automatic model_reset();
        owner = 0; b_served_last = 1'b1; waited = 0;
        e_valid = 1'b0; e_wr = 1'b0; e_sel = 1'b0; e_gnt_a = 1'b0; e_gnt_b = 1'b0;
        e_done_a = 1'b0; e_done_b = 1'b0; e_err = 1'b0;
        e_addr = '0; e_wdata = '0; e_rdata = '0;
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic model_step();
        bit want_a, want_b, fin, timed_out;
        int pick;
        want_a = ReqA && !e_done_a;
        want_b = ReqB && !e_done_b;
        e_done_a = 1'b0; e_done_b = 1'b0; e_err = 1'b0;
        if (owner == 0) begin
            if (want_a && want_b) pick = b_served_last ? 1 : 2;
            else if (want_a)      pick = 1;
            else if (want_b)      pick = 2;
            else                  pick = 0;
            if (pick != 0) begin
                owner = pick; waited = 0; e_valid = 1'b1;
                e_sel = (pick == 2); e_gnt_a = (pick == 1); e_gnt_b = (pick == 2);
                b_served_last = (pick == 2);
                e_addr  = (pick == 1) ? AddrA  : AddrB;
                e_wdata = (pick == 1) ? WDataA : WDataB;
                e_wr    = (pick == 1) ? WrA    : WrB;
            end
        end else begin
            fin = MemReady; timed_out = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            if (!MemReady && waited == TMO) begin fin = 1'b1; timed_out = 1'b1; end
`endif
            if (fin) begin
                if (!timed_out && !e_wr) e_rdata = MemRData;
                e_done_a = (owner == 1); e_done_b = (owner == 2); e_err = timed_out;
                e_gnt_a = 1'b0; e_gnt_b = 1'b0; e_valid = 1'b0; e_wr = 1'b0; owner = 0;
            end else begin
                waited++;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("MemValid", MemValid, e_valid);
        check_eq("MemAddr", MemAddr, e_addr);
        check_eq("MemWData", MemWData, e_wdata);
        check_eq("MemWr", MemWr, e_wr);
        check_eq("Sel", Sel, e_sel);
        check_eq("GntA", GntA, e_gnt_a);
        check_eq("GntB", GntB, e_gnt_b);
        check_eq("DoneA", DoneA, e_done_a);
        check_eq("DoneB", DoneB, e_done_b);
        check_eq("RData", RData, e_rdata);
        check_eq("Err", Err, e_err);
        check_eq("gnt_exclusive", GntA & GntB, 1'b0);
    endtask

    task automatic cycle();
        model_step();
        @(posedge Clk);
        #1;
        compare_all();
    endtask

    // Assert reset away from the clock edge; called at posedge+1.
    task automatic do_reset();
        #2;
        Reset_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge Clk);
        #1;
        compare_all();
        Reset_n = 1'b1;
    endtask

    task automatic new_op_a();
        ReqA = 1'b1; AddrA = $urandom; WDataA = $urandom; WrA = 1'($urandom_range(0, 1));
    endtask

    task automatic new_op_b();
        ReqB = 1'b1; AddrB = $urandom; WDataB = $urandom; WrB = 1'($urandom_range(0, 1));
    endtask

    // Protocol-respecting random requesters: operands held until Done.
    task automatic drive_random();
        if (!ReqA) begin
            if ($urandom_range(0, 9) < 4) new_op_a();
        end else if (e_done_a) begin
            if ($urandom_range(0, 1) == 0) ReqA = 1'b0; else new_op_a();
        end
        if (!ReqB) begin
            if ($urandom_range(0, 9) < 4) new_op_b();
        end else if (e_done_b) begin
            if ($urandom_range(0, 1) == 0) ReqB = 1'b0; else new_op_b();
        end
        MemReady = ($urandom_range(0, 9) < 4);
        MemRData = $urandom;
    endtask

    initial begin
        model_reset();
        @(posedge Clk);
        #1;
        compare_all();
        Reset_n = 1'b1;

        // Single read from A with memory always ready.
        ReqA = 1'b1; AddrA = 32'h0000_0100; WrA = 1'b0; WDataA = 32'h0;
        MemReady = 1'b1; MemRData = 32'hDEAD_BEEF;
        cycle();
        check_eq("t1_sel", Sel, 1'b0);
        check_eq("t1_valid", MemValid, 1'b1);
        check_eq("t1_addr", MemAddr, 32'h0000_0100);
        cycle();
        check_eq("t1_done", DoneA, 1'b1);
        check_eq("t1_rdata", RData, 32'hDEAD_BEEF);
        check_eq("t1_valid_off", MemValid, 1'b0);
        ReqA = 1'b0;
        cycle();
        check_eq("t1_done_pulse", DoneA, 1'b0);

        // Both requesters held high: grants alternate A,B,A,B.
        do_reset();
        ReqA = 1'b1; AddrA = 32'h0000_00A0; WrA = 1'b0;
        ReqB = 1'b1; AddrB = 32'h0000_00B0; WrB = 1'b0;
        MemReady = 1'b1; MemRData = 32'hDEAD_BEEF;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check_eq("t2_gnt_a", GntA, (i % 4 == 0));
            check_eq("t2_gnt_b", GntB, (i % 4 == 2));
            check_eq("t2_done_a", DoneA, (i % 4 == 1));
            check_eq("t2_done_b", DoneB, (i % 4 == 3));
        end
        ReqA = 1'b0; ReqB = 1'b0;
        cycle();

        // B write with a slow memory: port stays stable, RData untouched.
        ReqB = 1'b1; AddrB = 32'h0000_2000; WDataB = 32'h1234_5678; WrB = 1'b1;
        MemReady = 1'b0; MemRData = 32'hCAFE_F00D;
        for (int k = 0; k <= WAITS; k++) begin
            cycle();
            check_eq("t3_valid", MemValid, 1'b1);
            check_eq("t3_addr", MemAddr, 32'h0000_2000);
            check_eq("t3_wdata", MemWData, 32'h1234_5678);
            check_eq("t3_wr", MemWr, 1'b1);
            check_eq("t3_sel", Sel, 1'b1);
            check_eq("t3_no_done", DoneB, 1'b0);
        end
        MemReady = 1'b1;
        cycle();
        check_eq("t3_done", DoneB, 1'b1);
        check_eq("t3_rdata_kept", RData, 32'hDEAD_BEEF);
        ReqB = 1'b0; MemReady = 1'b0;
        cycle();
        check_eq("t3_done_pulse", DoneB, 1'b0);

        // Reset while B is busy, A pending: abandoned, then A wins first.
        ReqB = 1'b1; AddrB = 32'h0000_3000; WrB = 1'b0;
        MemRData = 32'h1111_1111;
        cycle();
        check_eq("t4_gnt_b", GntB, 1'b1);
        ReqA = 1'b1; AddrA = 32'h0000_0400; WrA = 1'b0;
        cycle();
        check_eq("t4_gnt_a_blocked", GntA, 1'b0);
        #2;
        Reset_n = 1'b0;
        model_reset();
        #1;
        check_eq("t4_rst_valid", MemValid, 1'b0);
        check_eq("t4_rst_gnt_b", GntB, 1'b0);
        check_eq("t4_rst_done_b", DoneB, 1'b0);
        compare_all();
        @(posedge Clk);
        #1;
        check_eq("t4_rst_done_b2", DoneB, 1'b0);
        Reset_n = 1'b1;
        cycle();
        check_eq("t4_first_gnt_a", GntA, 1'b1);
        check_eq("t4_first_addr", MemAddr, 32'h0000_0400);
        MemReady = 1'b1;
        cycle();
        check_eq("t4_done_a", DoneA, 1'b1);
        ReqA = 1'b0;
        cycle();
        check_eq("t4_then_gnt_b", GntB, 1'b1);
        cycle();
        check_eq("t4_done_b", DoneB, 1'b1);
        ReqB = 1'b0; MemReady = 1'b0;
        cycle();

`ifdef MEM_ARB_TIMEOUT_EN
        // Timeout abort, then a completion on the terminal edge.
        ReqA = 1'b1; AddrA = 32'h0000_0500; WrA = 1'b0; MemReady = 1'b0;
        cycle();
        for (int k = 0; k < TMO; k++) begin
            cycle();
            check_eq("t5_wait_done", DoneA, 1'b0);
        end
        cycle();
        check_eq("t5_tmo_done", DoneA, 1'b1);
        check_eq("t5_tmo_err", Err, 1'b1);
        check_eq("t5_tmo_rdata", RData, 32'h1111_1111);
        ReqA = 1'b0;
        cycle();
        check_eq("t5_err_pulse", Err, 1'b0);
        ReqA = 1'b1;
        cycle();
        for (int k = 0; k < TMO; k++) cycle();
        MemReady = 1'b1; MemRData = 32'h2222_2222;
        cycle();
        check_eq("t5_late_done", DoneA, 1'b1);
        check_eq("t5_late_err", Err, 1'b0);
        check_eq("t5_late_rdata", RData, 32'h2222_2222);
        ReqA = 1'b0; MemReady = 1'b0;
        cycle();
`endif

        // Randomized traffic against the reference model.
        ReqA = 1'b0; ReqB = 1'b0;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            drive_random();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
